// File: rtl/mem_write_queue_if.sv
// Write-queue bus: enqueue handshake, drain enable and the parallel memory write ports.
interface mem_write_queue_if #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDRBITS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned WRITERS  = 3
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                        enq_valid;
  logic                        enq_ready;
  logic [ADDRBITS-1:0]         enq_addr;
  logic [WIDTH-1:0]            enq_data;
  logic                        drain_en;
  logic [WRITERS-1:0]          wr_enas;
  logic [ADDRBITS*WRITERS-1:0] wr_addrs;
  logic [WIDTH*WRITERS-1:0]    wr_datas;
  logic [CW-1:0]               count;
  logic                        empty;

  modport master (
    output enq_valid, enq_addr, enq_data, drain_en,
    input  enq_ready, wr_enas, wr_addrs, wr_datas, count, empty
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, drain_en,
    output enq_ready, wr_enas, wr_addrs, wr_datas, count, empty
  );
endinterface

// File: rtl/mem_write_queue.sv
// Write-side FIFO that drains up to WRITERS entries per cycle onto the
// memory's parallel write ports, oldest entry on port 0.
// Optional macro MEM_WRITE_QUEUE_BYPASS_EN: an empty queue with drain enabled
// forwards a new request straight to port 0 in the same cycle.
module mem_write_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDRBITS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned WRITERS  = 3
) (
  input logic             clock,
  input logic             reset,
  mem_write_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDRBITS-1:0] mem_addr [DEPTH];
  logic [WIDTH-1:0]    mem_data [DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;

  logic          enq_fire;
  logic          bypass;
  logic          store;
  logic [CW-1:0] pop_n;
  logic [PW-1:0] idx;

  // Accept/drain decisions from the registered count only.
  always_comb begin
    bus.enq_ready = (count < CW'(DEPTH));
    enq_fire      = bus.enq_valid && bus.enq_ready;
    pop_n         = '0;
    if (bus.drain_en) begin
      pop_n = (count < CW'(WRITERS)) ? count : CW'(WRITERS);
    end
    bypass = 1'b0;
`ifdef MEM_WRITE_QUEUE_BYPASS_EN
    bypass = bus.drain_en && bus.enq_valid && (count == '0);
`endif
    store = enq_fire && !bypass;
  end

  // Head entry k drives port k; unused ports are held at zero.
  always_comb begin
    bus.wr_enas  = '0;
    bus.wr_addrs = '0;
    bus.wr_datas = '0;
    idx          = '0;
    for (int k = 0; k < int'(WRITERS); k++) begin
      if (CW'(k) < pop_n) begin
        idx                                = head + PW'(k);
        bus.wr_enas[k]                     = 1'b1;
        bus.wr_addrs[k*ADDRBITS +: ADDRBITS] = mem_addr[idx];
        bus.wr_datas[k*WIDTH +: WIDTH]       = mem_data[idx];
      end
    end
`ifdef MEM_WRITE_QUEUE_BYPASS_EN
    if (bypass) begin
      bus.wr_enas[0]               = 1'b1;
      bus.wr_addrs[ADDRBITS-1:0]   = bus.enq_addr;
      bus.wr_datas[WIDTH-1:0]      = bus.enq_data;
    end
`endif
  end

  assign bus.count = count;
  assign bus.empty = (count == '0);

  // Pointer and occupancy update; reset discards all queued writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(store);
      count <= count + CW'(store) - pop_n;
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clock) begin
    if (store) begin
      mem_addr[tail] <= bus.enq_addr;
      mem_data[tail] <= bus.enq_data;
    end
  end
endmodule

// File: tb/tb_mem_write_queue.sv
// Scoreboard bench for mem_write_queue: the driver keeps an abstract occupancy
// model and queues expected writes; the monitor checks every cycle's outputs.
module tb_mem_write_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AB    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned NW    = 3;

  typedef struct {
    int n;
    int cnt;
    bit rdy;
  } cyc_t;

  typedef struct {
    logic [AB-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_write_queue_if #(.DEPTH(DEPTH), .ADDRBITS(AB), .WIDTH(DW), .WRITERS(NW)) bus ();

  mem_write_queue #(.DEPTH(DEPTH), .ADDRBITS(AB), .WIDTH(DW), .WRITERS(NW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  cyc_t cyc_q[$];
  ent_t data_q[$];
  int   occ = 0;
  int   vectors = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, predict this cycle's outputs, advance the model.
  task automatic step(input bit v, input int a, input int d, input bit de, input bit rs);
    int   n;
    bit   acc;
    bit   byp;
    ent_t e;
    @(posedge clk);
    #1;
    bus.enq_valid = v;
    bus.enq_addr  = AB'(a);
    bus.enq_data  = DW'(d);
    bus.drain_en  = de;
    rst           = rs;
    n   = de ? ((occ < int'(NW)) ? occ : int'(NW)) : 0;
    acc = v && (occ < int'(DEPTH));
    byp = 1'b0;
`ifdef MEM_WRITE_QUEUE_BYPASS_EN
    byp = (occ == 0) && de && v;
`endif
    cyc_q.push_back('{n: (byp ? 1 : n), cnt: occ, rdy: (occ < int'(DEPTH))});
    if (acc) begin
      e.a = AB'(a);
      e.d = DW'(d);
      data_q.push_back(e);
    end
    if (rs) begin
      occ = 0;
      data_q.delete();
    end else begin
      occ = occ + ((acc && !byp) ? 1 : 0) - n;
    end
  endtask

  // Monitor: compare each cycle's outputs against the queued expectations.
  always @(negedge clk) begin
    cyc_t c;
    ent_t e;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("enq_ready", int'(bus.enq_ready), int'(c.rdy));
      chk("count", int'(bus.count), c.cnt);
      chk("empty", int'(bus.empty), int'(c.cnt == 0));
      chk("wr_enas", int'(bus.wr_enas), (1 << c.n) - 1);
      for (int k = 0; k < int'(NW); k++) begin
        if (k < c.n) begin
          if (data_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = data_q.pop_front();
            chk("wr_addr", int'(bus.wr_addrs[k*AB +: AB]), int'(e.a));
            chk("wr_data", int'(bus.wr_datas[k*DW +: DW]), int'(e.d));
          end
        end else begin
          chk("idle_addr", int'(bus.wr_addrs[k*AB +: AB]), 0);
          chk("idle_data", int'(bus.wr_datas[k*DW +: DW]), 0);
        end
      end
    end
  end

  initial begin
    bus.enq_valid = 1'b0;
    bus.enq_addr  = '0;
    bus.enq_data  = '0;
    bus.drain_en  = 1'b0;
    repeat (2) @(posedge clk);

    // Single write with drain enabled, then idle cycles.
    step(1'b1, 3, 8'h11, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0);

    // Fill to full with drain held off; ninth request refused, then burst drain.
    for (int i = 0; i < 9; i++) step(1'b1, i, 8'h80 + i, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b1, 1'b0);

    // Three writes to one address drained together in program order.
    step(1'b1, 5, 8'h01, 1'b0, 1'b0);
    step(1'b1, 5, 8'h02, 1'b0, 1'b0);
    step(1'b1, 5, 8'h03, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0);

    // Full queue with enqueue and drain both requested.
    for (int i = 0; i < 8; i++) step(1'b1, i + 8, 8'hA0 + i, 1'b0, 1'b0);
    step(1'b1, 1, 8'hB0, 1'b1, 1'b0);
    step(1'b1, 2, 8'hB1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0);

    // Steady enqueue with drain toggling; pointers wrap several times.
    for (int i = 0; i < 40; i++) step(1'b1, $urandom_range(0, 15), $urandom_range(0, 255), i[0], 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b1, 1'b0);

    // Reset with five entries held; nothing stale may follow.
    for (int i = 0; i < 5; i++) step(1'b1, i, 8'hC0 + i, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 15), $urandom_range(0, 255),
           ($urandom_range(0, 2) != 0), 1'b0);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    chk("leftover_writes", data_q.size(), 0);
    chk("leftover_cycles", cyc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
